// File: rtl/aer_sample_sequencer.sv
// aer_sample_sequencer
// Streams the events of one sample from a valid/ready source into a core
// over a 4-phase REQ/ACK link. It latches the sample polarity and mode,
// captures the core's goodness result and signals completion. A watchdog
// aborts a sample that stalls on the core side.
//
// Handshake semantics (both sides of the block):
//   Event source: an event is transferred on a rising CLK edge where
//     EVT_VALID and EVT_READY are both 1. EVT_READY is registered and is
//     high only while the FSM sits in FETCH, so at most one event is
//     taken per FETCH visit.
//   Core link: strict 4-phase. AERIN_ADDR is valid and stable whenever
//     AERIN_REQ is 1. REQ rises only after ACK has been seen low, and it
//     falls on the edge after ACK is seen high. The event counts as
//     delivered when ACK is then seen low again.
module aer_sample_sequencer #(
  parameter int AER_WIDTH      = 12,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 START_IS_POS,
  input  logic                 START_IS_TRAIN,
  input  logic [CNT_WIDTH-1:0] NUM_EVENTS,
  input  logic [AER_WIDTH-1:0] EVT_DATA,
  input  logic                 EVT_VALID,
  output logic                 EVT_READY,
  output logic [AER_WIDTH-1:0] AERIN_ADDR,
  output logic                 AERIN_REQ,
  input  logic                 AERIN_ACK,
  output logic                 IS_POS,
  output logic                 IS_TRAIN,
  input  logic                 PROCESS_DONE,
  input  logic [31:0]          GOODNESS,
  output logic [31:0]          GOODNESS_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TIMEOUT_ERR,
  output logic [2:0]           DBG_STATE
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    REQ_HI    = 3'd2,
    ACK_LO    = 3'd3,
    WAIT_DONE = 3'd4,
    RESULT    = 3'd5
  } state_t;

  // Watchdog is wide enough to hold TIMEOUT_CYCLES itself.
  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The watchdog fires on the edge where it has already counted
  // TIMEOUT_CYCLES-1, so REQ is held for exactly TIMEOUT_CYCLES cycles.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [1:0]           rst_sync;
  logic                 run_en;
  logic [CNT_WIDTH-1:0] num_lat;
  logic [CNT_WIDTH-1:0] evt_cnt;
  logic [CNT_WIDTH-1:0] evt_cnt_next;
  logic [WD_W-1:0]      wdog;
  logic                 wd_expired;

  // Reset release is re-timed to CLK; the FSM may not leave IDLE until
  // both stages have seen RST_N high. Assertion stays asynchronous.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run_en = rst_sync[1];

  // Saturating increment: the count never passes the latched target.
  assign evt_cnt_next = (evt_cnt == num_lat) ? evt_cnt : evt_cnt + CNT_WIDTH'(1);

  assign wd_expired = (wdog == WD_LAST);

  assign DBG_STATE = state;

  // Sample sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      num_lat      <= '0;
      evt_cnt      <= '0;
      wdog         <= '0;
      EVT_READY    <= 1'b0;
      AERIN_ADDR   <= '0;
      AERIN_REQ    <= 1'b0;
      IS_POS       <= 1'b0;
      IS_TRAIN     <= 1'b0;
      GOODNESS_OUT <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      TIMEOUT_ERR  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          // START is only honoured here, so a pulse while busy changes nothing.
          if (START && run_en) begin
            IS_POS      <= START_IS_POS;
            IS_TRAIN    <= START_IS_TRAIN;
            num_lat     <= NUM_EVENTS;
            evt_cnt     <= '0;
            wdog        <= '0;
            TIMEOUT_ERR <= 1'b0;
            BUSY        <= 1'b1;
            if (NUM_EVENTS == '0) begin
              // An empty sample reports a zero result.
              GOODNESS_OUT <= '0;
              state        <= RESULT;
            end else begin
              EVT_READY <= 1'b1;
              state     <= FETCH;
            end
          end
        end

        FETCH: begin
          // Waiting on the source is not a core stall: no watchdog here.
          if (EVT_VALID) begin
            AERIN_ADDR <= EVT_DATA;
            EVT_READY  <= 1'b0;
            AERIN_REQ  <= 1'b1;
            wdog       <= '0;
            state      <= REQ_HI;
          end
        end

        REQ_HI: begin
          if (AERIN_ACK) begin
            AERIN_REQ <= 1'b0;
            wdog      <= '0;
            state     <= ACK_LO;
          end else if (wd_expired) begin
            AERIN_REQ   <= 1'b0;
            TIMEOUT_ERR <= 1'b1;
            wdog        <= '0;
            state       <= RESULT;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end

        ACK_LO: begin
          // The next REQ is only possible after ACK has returned low.
          if (!AERIN_ACK) begin
            evt_cnt <= evt_cnt_next;
            wdog    <= '0;
            if (evt_cnt_next == num_lat) begin
              state <= WAIT_DONE;
            end else begin
              EVT_READY <= 1'b1;
              state     <= FETCH;
            end
          end else if (wd_expired) begin
            TIMEOUT_ERR <= 1'b1;
            wdog        <= '0;
            state       <= RESULT;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end

        WAIT_DONE: begin
          if (PROCESS_DONE) begin
            GOODNESS_OUT <= GOODNESS;
            wdog         <= '0;
            state        <= RESULT;
          end else if (wd_expired) begin
            TIMEOUT_ERR <= 1'b1;
            wdog        <= '0;
            state       <= RESULT;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end

        RESULT: begin
          // Single-cycle completion pulse; GOODNESS_OUT is left as captured.
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          wdog  <= '0;
          state <= IDLE;
        end

        default: begin
          EVT_READY <= 1'b0;
          AERIN_REQ <= 1'b0;
          BUSY      <= 1'b0;
          wdog      <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aer_sample_sequencer.sv
// Directed bench for aer_sample_sequencer: event source driver, 4-phase
// core responder, and scoreboards for delivered addresses and results.
module tb_aer_sample_sequencer;

  localparam int AW = 12;
  localparam int CW = 16;
  localparam int TO = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, start_is_pos, start_is_train;
  logic [CW-1:0] num_events;
  logic [AW-1:0] evt_data;
  logic          evt_valid, evt_ready;
  logic [AW-1:0] aerin_addr;
  logic          aerin_req, aerin_ack;
  logic          is_pos, is_train, process_done;
  logic [31:0]   goodness, goodness_out;
  logic          busy, done, timeout_err;
  logic [2:0]    dbg_state;

  aer_sample_sequencer #(
    .AER_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .START(start),
    .START_IS_POS(start_is_pos), .START_IS_TRAIN(start_is_train),
    .NUM_EVENTS(num_events), .EVT_DATA(evt_data), .EVT_VALID(evt_valid),
    .EVT_READY(evt_ready), .AERIN_ADDR(aerin_addr), .AERIN_REQ(aerin_req),
    .AERIN_ACK(aerin_ack), .IS_POS(is_pos), .IS_TRAIN(is_train),
    .PROCESS_DONE(process_done), .GOODNESS(goodness),
    .GOODNESS_OUT(goodness_out), .BUSY(busy), .DONE(done),
    .TIMEOUT_ERR(timeout_err), .DBG_STATE(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboards: addresses expected on the core link, and {timeout, goodness}
  // expected at each DONE pulse.
  logic [AW-1:0] exp_q[$];
  logic [32:0]   exp_done_q[$];

  int req_rises = 0;
  int req_len = 0;
  int last_req_len = 0;
  int done_count = 0;
  logic req_prev = 1'b0;
  logic [AW-1:0] addr_at_rise = '0;

  // Core model controls
  int   ack_lat = 2;
  logic never_ack = 1'b0;
  int   ack_wait = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Core responder: raises ACK ack_lat cycles after seeing REQ, drops it
  // once REQ is seen low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aerin_ack <= 1'b0;
      ack_wait  <= 0;
    end else if (aerin_req && !aerin_ack) begin
      if (!never_ack) begin
        if (ack_wait >= ack_lat - 1) begin
          aerin_ack <= 1'b1;
          ack_wait  <= 0;
        end else begin
          ack_wait <= ack_wait + 1;
        end
      end
    end else if (!aerin_req) begin
      aerin_ack <= 1'b0;
      ack_wait  <= 0;
    end
  end

  // Monitor: sampled on the falling edge, away from DUT updates.
  initial begin
    forever begin
      @(negedge clk);
      if (aerin_req && !req_prev) begin
        req_rises++;
        req_len = 0;
        addr_at_rise = aerin_addr;
        check("req_rise_with_ack_low", aerin_ack, 0);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_req: observed addr %0h expected no request", aerin_addr);
        end
        if (exp_q.size() != 0) check("aerin_addr", aerin_addr, exp_q.pop_front());
      end
      if (aerin_req) begin
        req_len++;
        check("addr_stable_under_req", aerin_addr, addr_at_rise);
      end
      if (!aerin_req && req_prev) last_req_len = req_len;
      req_prev = aerin_req;
      if (done) begin
        done_count++;
        checks++;
        assert (exp_done_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_done: observed DONE=1 expected none");
        end
        if (exp_done_q.size() != 0) begin
          logic [32:0] e;
          e = exp_done_q.pop_front();
          check("timeout_err_at_done", timeout_err, e[32]);
          check("goodness_out_at_done", goodness_out, e[31:0]);
        end
      end
    end
  end

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic launch(input logic pos, input logic train, input logic [CW-1:0] n);
    start_is_pos = pos;
    start_is_train = train;
    num_events = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_event(input logic [AW-1:0] d);
    int n;
    n = 0;
    exp_q.push_back(d);
    evt_data = d;
    evt_valid = 1'b1;
    while (evt_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("evt_accept_in_budget", (n < 200), 1);
    @(negedge clk);
    evt_valid = 1'b0;
    evt_data = AW'($urandom_range(0, 4095));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_in_budget", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rises0;
    logic [31:0] g;
    logic [AW-1:0] a0, a1;

    start = 0; start_is_pos = 0; start_is_train = 0; num_events = '0;
    evt_data = '0; evt_valid = 0; process_done = 0; goodness = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", aerin_req, 0);
    check("rst_addr", aerin_addr, 0);
    check("rst_ready", evt_ready, 0);
    check("rst_is_pos", is_pos, 0);
    check("rst_is_train", is_train, 0);
    check("rst_goodness_out", goodness_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Three events, ACK after 2 cycles, stray PROCESS_DONE mid-stream
    rises0 = req_rises;
    ack_lat = 2;
    launch(1'b1, 1'b0, 16'd3);
    exp_done_q.push_back({1'b0, 32'h0000_1234});
    check("t1_is_pos", is_pos, 1);
    check("t1_is_train", is_train, 0);
    check("t1_busy", busy, 1);
    send_event(12'h005);
    goodness = 32'h0000_DEAD;
    process_done = 1'b1;
    @(negedge clk);
    process_done = 1'b0;
    send_event(12'h123);
    send_event(12'h30F);
    goodness = 32'h0000_1234;
    process_done = 1'b1;
    wait_done(200);
    process_done = 1'b0;
    check("t1_req_count", req_rises - rises0, 3);
    check("t1_goodness_out", goodness_out, 32'h0000_1234);
    check("t1_busy_after", busy, 0);

    // Core never acknowledges: watchdog aborts after TO cycles of REQ
    never_ack = 1'b1;
    launch(1'b0, 1'b1, 16'd1);
    exp_done_q.push_back({1'b1, 32'h0000_1234});
    send_event(12'h0AA);
    wait_done(100);
    check("t2_req_len", last_req_len, TO);
    check("t2_req_low", aerin_req, 0);
    check("t2_timeout_sticky", timeout_err, 1);
    never_ack = 1'b0;

    // Empty sample: DONE two cycles after START, zero result, no REQ
    rises0 = req_rises;
    exp_done_q.push_back({1'b0, 32'h0});
    launch(1'b1, 1'b1, 16'd0);
    check("t3_timeout_cleared", timeout_err, 0);
    check("t3_done_not_yet", done, 0);
    check("t3_busy", busy, 1);
    @(negedge clk);
    check("t3_done_pulse", done, 1);
    check("t3_goodness_zero", goodness_out, 0);
    @(negedge clk);
    check("t3_done_low", done, 0);
    check("t3_no_req", req_rises - rises0, 0);

    // START while busy with other polarity/mode/count is ignored
    rises0 = req_rises;
    ack_lat = $urandom_range(1, 4);
    g = $urandom;
    a0 = AW'($urandom_range(0, 4095));
    a1 = AW'($urandom_range(0, 4095));
    launch(1'b1, 1'b1, 16'd2);
    exp_done_q.push_back({1'b0, g});
    send_event(a0);
    launch(1'b0, 1'b0, 16'd5);
    check("t4_is_pos_held", is_pos, 1);
    check("t4_is_train_held", is_train, 1);
    send_event(a1);
    goodness = g;
    process_done = 1'b1;
    wait_done(200);
    process_done = 1'b0;
    check("t4_req_count", req_rises - rises0, 2);
    check("t4_is_pos_after", is_pos, 1);

    // Reset in the middle of a request, then a normal sample
    never_ack = 1'b1;
    launch(1'b1, 1'b1, 16'd1);
    send_event(12'h7FF);
    check("t5_req_before_rst", aerin_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_req", aerin_req, 0);
    check("t5_rst_addr", aerin_addr, 0);
    check("t5_rst_ready", evt_ready, 0);
    check("t5_rst_is_pos", is_pos, 0);
    check("t5_rst_is_train", is_train, 0);
    check("t5_rst_goodness", goodness_out, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_timeout", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    never_ack = 1'b0;
    repeat (3) @(negedge clk);
    g = $urandom;
    launch(1'b0, 1'b1, 16'd1);
    exp_done_q.push_back({1'b0, g});
    send_event(12'h0C3);
    goodness = g;
    process_done = 1'b1;
    wait_done(200);
    process_done = 1'b0;

    // Long source stall in FETCH must not trip the watchdog
    g = $urandom;
    launch(1'b1, 1'b0, 16'd1);
    exp_done_q.push_back({1'b0, g});
    repeat (100) @(negedge clk);
    check("t6_no_timeout", timeout_err, 0);
    check("t6_busy", busy, 1);
    check("t6_ready", evt_ready, 1);
    send_event(AW'($urandom_range(0, 4095)));
    goodness = g;
    process_done = 1'b1;
    wait_done(200);
    process_done = 1'b0;

    // Final report
    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_done_q_drained", exp_done_q.size(), 0);
    check("done_count", done_count, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
